// File: rtl/i2c_slave_target_if.sv
// Local-side handshake between i2c_slave_target and the logic that consumes
// written bytes and supplies read bytes.
interface i2c_slave_target_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       sda_drive_low;

  modport slave  (input  tx_data,
                  output rx_data, rx_valid, tx_req, busy, sda_drive_low);
  modport master (output tx_data,
                  input  rx_data, rx_valid, tx_req, busy, sda_drive_low);
endinterface

// File: rtl/i2c_slave_target.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detect, address ACK,
// byte write/read with open-drain SDA. Define I2C_SLAVE_GENCALL_EN to ACK general call.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  i2c_slave_target_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]   shreg, shreg_nxt;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_nxt;
  logic                rx_valid_q, rx_valid_nxt;
  logic                tx_req_q, tx_req_nxt;
  logic                busy_q, busy_nxt;
  logic                drive_q, drive_nxt;
  logic                nack_q, nack_nxt;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
    end else begin
      {scl_meta, scl_sync, scl_prev} <= {i2c_scl, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {i2c_sda, sda_meta, sda_sync};
    end
  end

  logic              scl_rise_c, scl_fall_c, start_c, stop_c, addr_hit_c;
  logic [BYTE_W-1:0] shift_in_c;

  assign scl_rise_c = scl_sync & ~scl_prev;
  assign scl_fall_c = ~scl_sync & scl_prev;
  assign start_c    = scl_sync & scl_prev & ~sda_sync & sda_prev;
  assign stop_c     = scl_sync & scl_prev & sda_sync & ~sda_prev;
  assign shift_in_c = {shreg[BYTE_W-2:0], sda_sync};

`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_hit_c = (shift_in_c[7:1] == SLAVE_ADDR) || (shift_in_c == 8'h00);
`else
  assign addr_hit_c = (shift_in_c[7:1] == SLAVE_ADDR);
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= CNT_W'(7);
      shreg      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      rx_data_q  <= rx_data_nxt;
      rx_valid_q <= rx_valid_nxt;
      tx_req_q   <= tx_req_nxt;
      busy_q     <= busy_nxt;
      drive_q    <= drive_nxt;
      nack_q     <= nack_nxt;
    end
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = ADDR;
    end else if (stop_c) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR:      if (scl_rise_c && bit_cnt == '0) state_nxt = addr_hit_c ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall_c && drive_q) state_nxt = shreg[0] ? READ : WRITE;
        WRITE:     if (scl_rise_c && bit_cnt == '0) state_nxt = WRITE_ACK;
        WRITE_ACK: if (scl_fall_c && drive_q) state_nxt = WRITE;
        READ:      if (!tx_req_q && scl_fall_c && bit_cnt == '0) state_nxt = READ_ACK;
        READ_ACK:  if (scl_fall_c) state_nxt = nack_q ? IDLE : READ;
        default:   state_nxt = state;
      endcase
    end
  end

  // Datapath and output next values; SDA only moves on scl_fall
  always_comb begin
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    rx_data_nxt  = rx_data_q;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    busy_nxt     = busy_q;
    drive_nxt    = drive_q;
    nack_nxt     = nack_q;
    if (start_c) begin
      bit_cnt_nxt = CNT_W'(7);
      drive_nxt   = 1'b0;
    end else if (stop_c) begin
      drive_nxt = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise_c) begin
          shreg_nxt = shift_in_c;
          if (bit_cnt == '0) begin
            busy_nxt    = addr_hit_c;
            bit_cnt_nxt = CNT_W'(7);
          end else begin
            bit_cnt_nxt = bit_cnt - CNT_W'(1);
          end
        end
        ADDR_ACK: if (scl_fall_c) begin
          if (!drive_q)      drive_nxt  = 1'b1;
          else if (shreg[0]) tx_req_nxt = 1'b1;
          else               drive_nxt  = 1'b0;
        end
        WRITE: if (scl_rise_c) begin
          shreg_nxt = shift_in_c;
          if (bit_cnt == '0) begin
            rx_data_nxt  = shift_in_c;
            rx_valid_nxt = 1'b1;
            bit_cnt_nxt  = CNT_W'(7);
          end else begin
            bit_cnt_nxt = bit_cnt - CNT_W'(1);
          end
        end
        WRITE_ACK: if (scl_fall_c) drive_nxt = ~drive_q;
        READ: begin
          // The cycle after tx_req, tx_data is captured and its MSB driven
          if (tx_req_q) begin
            shreg_nxt = bus.tx_data;
            drive_nxt = ~bus.tx_data[7];
          end else if (scl_fall_c) begin
            if (bit_cnt == '0) begin
              drive_nxt = 1'b0;
            end else begin
              bit_cnt_nxt = bit_cnt - CNT_W'(1);
              shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
              drive_nxt   = ~shreg[BYTE_W-2];
            end
          end
        end
        READ_ACK: begin
          if (scl_rise_c) nack_nxt = sda_sync;
          if (scl_fall_c && !nack_q) begin
            tx_req_nxt  = 1'b1;
            bit_cnt_nxt = CNT_W'(7);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.tx_req        = tx_req_q;
  assign bus.busy          = busy_q;
  assign bus.sda_drive_low = drive_q;
  assign i2c_sda           = drive_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bit-banged I2C master driving i2c_slave_target; directed plan cases plus
// random transactions checked against a transaction-level expectation model.
module tb_i2c_slave_target;

  localparam int unsigned Q = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  i2c_sda;

  assign i2c_sda = m_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  i2c_slave_target_if bus ();

  i2c_slave_target #(.SLAVE_ADDR(7'h50)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_scl (scl),
    .i2c_sda (i2c_sda),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int txr_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] dq[$];

  always @(posedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= bus.rx_data;
    end
    if (bus.tx_req) txr_cnt <= txr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected address acknowledgement from the bus-address rules
  function automatic bit model_ack(input logic [7:0] ab);
    bit gc;
`ifdef I2C_SLAVE_GENCALL_EN
    gc = (ab == 8'h00);
`else
    gc = 1'b0;
`endif
    return (ab[7:1] == 7'h50) || gc;
  endfunction

  function automatic bit bus_sda();
    return (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    qwait(); m_low = 1'b0;
    qwait(); scl = 1'b1;
    qwait(); m_low = 1'b1;
    qwait(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    qwait(); m_low = 1'b1;
    qwait(); scl = 1'b1;
    qwait(); m_low = 1'b0;
    qwait();
  endtask

  task automatic put_bit(input bit b);
    qwait(); m_low = ~b;
    qwait(); scl = 1'b1;
    qwait(); qwait(); scl = 1'b0;
  endtask

  task automatic get_bit(output bit b);
    qwait(); m_low = 1'b0;
    qwait(); scl = 1'b1;
    qwait(); b = bus_sda();
    qwait(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ack);
    bit a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    ack = ~a;
  endtask

  task automatic wr_txn(input logic [7:0] ab, input logic [7:0] d[$], input bit stop, input string tag);
    int rc0;
    bit exp_ack, ack;
    rc0 = rx_cnt;
    exp_ack = model_ack(ab);
    i2c_start();
    send_byte(ab, ack);
    check({tag, "/addr_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "/busy"}, 32'(bus.busy), 32'(exp_ack));
    foreach (d[i]) begin
      send_byte(d[i], ack);
      check({tag, "/data_ack"}, 32'(ack), 32'(exp_ack));
      if (exp_ack) check({tag, "/rx_data"}, 32'(rx_last), 32'(d[i]));
    end
    check({tag, "/rx_count"}, 32'(rx_cnt - rc0), exp_ack ? 32'(d.size()) : 32'd0);
    if (stop) begin
      i2c_stop();
      check({tag, "/busy_after_stop"}, 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic rd_txn(input logic [7:0] ab, input logic [7:0] d[$], input string tag);
    int tc0;
    bit exp_ack, ack, b;
    logic [7:0] got;
    tc0 = txr_cnt;
    exp_ack = model_ack(ab);
    bus.tx_data = d[0];
    i2c_start();
    send_byte(ab, ack);
    check({tag, "/addr_ack"}, 32'(ack), 32'(exp_ack));
    foreach (d[i]) begin
      for (int k = 7; k >= 0; k--) begin
        get_bit(b);
        got[k] = b;
      end
      if (i + 1 < d.size()) bus.tx_data = d[i+1];
      put_bit(i == d.size() - 1);
      check({tag, "/rd_byte"}, 32'(got), exp_ack ? 32'(d[i]) : 32'hFF);
    end
    qwait();
    check({tag, "/released_drive"}, 32'(bus.sda_drive_low), 32'd0);
    check({tag, "/released_bus"}, 32'(bus_sda()), 32'd1);
    check({tag, "/tx_req_count"}, 32'(txr_cnt - tc0), exp_ack ? 32'(d.size()) : 32'd0);
    i2c_stop();
    check({tag, "/busy_after_stop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [7:0] ab;
    int n;
    bus.tx_data = 8'h00;
    repeat (4) @(negedge clk);
    check("rst/rx_data", 32'(bus.rx_data), 32'd0);
    check("rst/rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst/tx_req", 32'(bus.tx_req), 32'd0);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/drive", 32'(bus.sda_drive_low), 32'd0);
    check("rst/bus_sda", 32'(bus_sda()), 32'd1);
    reset = 1'b0;
    qwait();

    dq = {8'h3C};
    wr_txn(8'hA0, dq, 1'b1, "wr50");

    dq = {8'hC5, 8'h5A};
    rd_txn(8'hA1, dq, "rd50");

    dq = {8'hFF};
    wr_txn(8'hA2, dq, 1'b1, "wr51");

    dq = {8'h11};
    wr_txn(8'hA0, dq, 1'b0, "wr_rs");
    check("wr_rs/rx_hold", 32'(bus.rx_data), 32'h11);
    dq = {8'h96};
    rd_txn(8'hA1, dq, "rd_rs");

    dq = {8'h06};
    wr_txn(8'h00, dq, 1'b1, "gcall");

    for (int t = 0; t < 6; t++) begin
      ab = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : {7'h50, 1'($urandom_range(0, 1))};
      n = $urandom_range(1, 3);
      dq = {};
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
      if (ab[0]) rd_txn(ab, dq, "rand_rd");
      else       wr_txn(ab, dq, 1'b1, "rand_wr");
    end

    // Reset while the target holds the address ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(1'((8'hA0 >> i) & 8'h01));
    qwait(); m_low = 1'b0;
    qwait(); scl = 1'b1;
    qwait();
    check("mid_ack/driving", 32'(bus.sda_drive_low), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_ack/drive", 32'(bus.sda_drive_low), 32'd0);
    check("mid_ack/bus_sda", 32'(bus_sda()), 32'd1);
    check("mid_ack/busy", 32'(bus.busy), 32'd0);
    check("mid_ack/rx_data", 32'(bus.rx_data), 32'd0);
    check("mid_ack/rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_ack/tx_req", 32'(bus.tx_req), 32'd0);
    @(negedge clk) reset = 1'b0;
    scl = 1'b0;
    i2c_stop();

    dq = {8'h77};
    wr_txn(8'hA0, dq, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

Single-address I2C target (slave) on the same two-wire bus as the team's I2C master, receiving its address, write and read transactions. Oversamples SCL/SDA on a local system clock, detects START/STOP, ACKs its own 7-bit address, and delivers written bytes to local logic. Supplies read bytes from local logic. Drives SDA open-drain only, never SCL.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- clk  input  1  system clock; all logic on posedge clk.
- reset  input  1  asynchronous, active-high.
- i2c_scl  input  1  bus clock (never driven).
- i2c_sda  inout  1  bus data; driven 0 when sda_drive_low=1, else high-Z.
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
- rx_data  output  8  last byte received in a write.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_req  output  1  one-cycle pulse when tx_data is loaded into the shifter.
- busy  output  1  high from an addressed START until STOP/release.
- sda_drive_low  output  1  internal drive enable, exported for debug.

## Operation
- Reset values: rx_data=0, rx_valid=0, tx_req=0, busy=0, sda_drive_low=0, state=IDLE, bit counter=7.
- Inputs pass a 2-flop synchronizer, then a 1-flop history. scl_rise/scl_fall/sda_rise/sda_fall are derived from the synchronized signals.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high. Both are honoured in every state.
  - START (including repeated) -> ADDR, counter=7, drive released.
  - STOP -> IDLE, busy=0, drive released.
- States:
  - IDLE: wait for START.
  - ADDR: shift SDA into an 8-bit register on each scl_rise, counter decrements. After bit 0 is shifted, go to ADDR_ACK.
    - If addr[7:1]==SLAVE_ADDR, set busy=1 and drive SDA low on the next scl_fall.
    - Otherwise go to IDLE without driving.
  - ADDR_ACK: hold SDA low through one SCL high phase. On the following scl_fall:
    - rw=0 -> release SDA, go to WRITE.
    - rw=1 -> pulse tx_req, load tx_data, drive bit 7 (0 -> low, 1 -> release), go to READ.
  - WRITE: shift in 8 bits MSB first on scl_rise. After the 8th bit: rx_data<=shifted byte, rx_valid pulse, drive low at next scl_fall, go to WRITE_ACK. WRITE_ACK releases on the following scl_fall and returns to WRITE with counter=7, so multi-byte writes are accepted.
  - READ: present next bit on each scl_fall, MSB first. After bit 0's SCL high phase, release SDA at scl_fall and go to READ_ACK.
  - READ_ACK: sample SDA on scl_rise.
    - 0 (ACK) -> on scl_fall pulse tx_req, reload, go to READ.
    - 1 (NACK) -> IDLE with drive released; bus stays idle until STOP/START.
- SDA is changed only on scl_fall, never while SCL high, except release on STOP/START.
- Simultaneous START and bit-edge in one cycle: START wins.
- Reset mid-transfer releases SDA in the same cycle (asynchronous).

## Timing
- Detection latency: 3 clk from a bus edge to the internal event.
- SDA drive change lands 4 clk after the true SCL fall.
- Bus requirement: SCL low ≥ 5 clk and SCL high ≥ 3 clk. With a master running on a shared clk, its divider must be ≥ 10.
- rx_valid asserts 4 clk after the SCL rise of the 8th data bit.
- tx_req asserts one cycle before the MSB appears on sda_drive_low.

## Configuration
- I2C_SLAVE_GENCALL_EN:
  - Defined: address 7'h00 with rw=0 (general call) is also ACKed. Subsequent bytes are received exactly as a normal write.
  - Undefined: 7'h00 is NACKed (ignored) like any non-matching address.

## Test plan
- Reset asserted mid-ACK -> i2c_sda high-Z in the same cycle, all outputs at reset values.
- START, byte 0xA0 (0x50 write), data 0x3C, STOP -> ACK driven in both ACK slots, rx_data=0x3C with a single rx_valid pulse, busy low after STOP.
- START, byte 0xA1 (0x50 read) with tx_data=0xC5, master ACK then second byte tx_data=0x5A with NACK, STOP:
  - bus carries 0xC5 then 0x5A;
  - two tx_req pulses;
  - SDA released after the NACK.
- START, address 0x51 write, data 0xFF -> no ACK, no rx_valid, busy stays 0.
- Write 0x11, then repeated START with a read of 0x50 -> rx_data=0x11, then the read phase starts correctly with counter=7.
- General call 0x00 write, data 0x06:
  - macro defined -> ACK and rx_data=0x06;
  - undefined -> NACK and no rx_valid.
